road_track_engine: RTL and testbench



---
 rtl/road_track_engine_if.sv | 24 ++
 rtl/road_track_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_road_track_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/road_track_engine_if.sv
// rtl/road_track_engine_if.sv - game strobes, VGA timing inputs and pixel/status outputs
interface road_track_engine_if;
    logic        tick;
    logic        start;
    logic        left;
    logic        right;
    logic        bright;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic [11:0] rgb;
    logic        dead_flag;
    logic [1:0]  state;
    logic [15:0] score;

    modport master (
        output tick, start, left, right, bright, hCount, vCount,
        input  rgb, dead_flag, state, score
    );

    modport slave (
        input  tick, start, left, right, bright, hCount, vCount,
        output rgb, dead_flag, state, score
    );
endinterface

// File: rtl/road_track_engine.sv
// rtl/road_track_engine.sv - scrolling curved road, player car, game FSM and pixel colour
module road_track_engine #(
    parameter int ROWS          = 480,
    parameter int X_MIN         = 144,
    parameter int X_MAX         = 783,
    parameter int V_START       = 35,
    parameter int ROAD_W_INIT   = 100,
    parameter int ROAD_W_MIN    = 40,
    parameter int SHRINK_PERIOD = 256,
    parameter int CURVE_MAX     = 3,
    parameter int CAR_ROW       = 340,
    parameter int CAR_HALF      = 5,
    parameter int CAR_STEP      = 2,
    parameter int CRASH_HOLD    = 60
) (
    input logic               clk,
    input logic               rst,
    road_track_engine_if.slave bus
);
    localparam int XW     = 10;
    localparam int AW     = $clog2(ROWS);
    localparam int SW     = $clog2(SHRINK_PERIOD + 1);
    localparam int HW     = $clog2(CRASH_HOLD + 1);
    localparam int CENTER = (X_MIN + X_MAX + 1) / 2;

    localparam logic [XW-1:0] INIT_LEFT  = XW'(CENTER - ROAD_W_INIT / 2);
    localparam logic [XW-1:0] INIT_RIGHT = XW'(CENTER - ROAD_W_INIT / 2 + ROAD_W_INIT);
    localparam logic [XW-1:0] CENTER_X   = XW'(CENTER);
    localparam logic [XW-1:0] W_INIT     = XW'(ROAD_W_INIT);
    localparam logic [XW-1:0] W_MIN      = XW'(ROAD_W_MIN);
    localparam logic [XW-1:0] W_MIN2     = XW'(ROAD_W_MIN + 2);
    localparam logic [XW-1:0] CAR_X_LO   = XW'(X_MIN + CAR_HALF);
    localparam logic [XW-1:0] CAR_X_HI   = XW'(X_MAX - CAR_HALF);
    localparam logic [XW-1:0] STEP       = XW'(CAR_STEP);
    localparam logic [XW:0]   HALF       = (XW+1)'(CAR_HALF);
    localparam logic [XW-1:0] CAR_V_LO   = XW'(CAR_ROW + V_START - CAR_HALF);
    localparam logic [XW-1:0] CAR_V_HI   = XW'(CAR_ROW + V_START + CAR_HALF);
    localparam logic [XW-1:0] V_FIRST    = XW'(V_START);
    localparam logic [XW:0]   V_END      = (XW+1)'(V_START + ROWS);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(ROWS - 1);
    localparam logic [AW-1:0] CAR_OFS    = AW'(CAR_ROW);
    localparam logic [7:0]    CURVE_MOD  = 8'(2 * CURVE_MAX + 1);
    localparam logic signed [XW+1:0] CURVE_S = (XW+2)'(CURVE_MAX);
    localparam logic signed [XW+1:0] X_MIN_S = (XW+2)'(X_MIN);
    localparam logic signed [XW+1:0] X_MAX_S = (XW+2)'(X_MAX);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_CRASH = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0] left_mem  [ROWS];
    logic [XW-1:0] right_mem [ROWS];

    logic [AW-1:0] init_addr, head;
    logic [XW-1:0] width, xpos;
    logic [15:0]   lfsr, score_q;
    logic [SW-1:0] shrink_cnt;
    logic [HW-1:0] hold_cnt;
    logic          dead_q;
    logic [11:0]   rgb_q;

    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (AW+1)'(ROWS))
            s = s - (AW+1)'(ROWS);
        return s[AW-1:0];
    endfunction

    // Collision looks at the row currently under the car
    logic [AW-1:0] car_addr;
    logic [XW-1:0] car_left, car_right;
    logic          crash;

    always_comb begin
        car_addr  = wrap_add(head, CAR_OFS);
        car_left  = left_mem[car_addr];
        car_right = right_mem[car_addr];
        crash     = (({1'b0, xpos} - HALF) < {1'b0, car_left}) ||
                    (({1'b0, xpos} + HALF) > {1'b0, car_right});
    end

    // Per-tick update values; only committed in RUN on a tick
    logic [15:0]            lfsr_next;
    logic [AW-1:0]          head_next;
    logic                   shrink_hit;
    logic [XW-1:0]          width_next;
    logic [7:0]             curve_mod;
    logic signed [XW+1:0]   cand, left_hi, new_left_s;
    logic [XW-1:0]          new_left, new_right;
    logic [XW:0]            x_plus;
    logic [XW-1:0]          xpos_next;

    always_comb begin
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        head_next  = (head == '0) ? LAST_ADDR : head - 1'b1;
        shrink_hit = (shrink_cnt == SW'(SHRINK_PERIOD - 1));
        width_next = width;
        if (shrink_hit)
            width_next = (width >= W_MIN2) ? width - 2'd2 : W_MIN;

        curve_mod  = lfsr_next[7:0] % CURVE_MOD;
        cand       = $signed({2'b00, left_mem[head]}) + $signed({4'b0000, curve_mod}) - CURVE_S;
        left_hi    = X_MAX_S - $signed({2'b00, width_next});
        new_left_s = cand;
        if (cand < X_MIN_S)
            new_left_s = X_MIN_S;
        else if (cand > left_hi)
            new_left_s = left_hi;
        new_left   = new_left_s[XW-1:0];
        new_right  = new_left + width_next;

        x_plus    = {1'b0, xpos} + {1'b0, STEP};
        xpos_next = xpos;
        if (bus.right && !bus.left)
            xpos_next = (x_plus > {1'b0, CAR_X_HI}) ? CAR_X_HI : x_plus[XW-1:0];
        else if (bus.left && !bus.right)
            xpos_next = (xpos < CAR_X_LO + STEP) ? CAR_X_LO : xpos - STEP;
    end

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [XW-1:0] wr_left, wr_right;

    always_comb begin
        wr_en    = 1'b0;
        wr_addr  = init_addr;
        wr_left  = INIT_LEFT;
        wr_right = INIT_RIGHT;
        if (state_q == ST_INIT) begin
            wr_en = 1'b1;
        end else if (state_q == ST_RUN && bus.tick) begin
            wr_en    = 1'b1;
            wr_addr  = head_next;
            wr_left  = new_left;
            wr_right = new_right;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            left_mem[wr_addr]  <= wr_left;
            right_mem[wr_addr] <= wr_right;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_addr == LAST_ADDR) state_d = ST_IDLE;
            ST_IDLE:  if (bus.start) state_d = ST_RUN;
            ST_RUN:   if (crash) state_d = ST_CRASH;
            ST_CRASH: if (bus.tick && hold_cnt == HW'(CRASH_HOLD - 1)) state_d = ST_INIT;
            default:  state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_INIT;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_addr  <= '0;
            head       <= '0;
            width      <= W_INIT;
            xpos       <= CENTER_X;
            lfsr       <= 16'hACE1;
            score_q    <= '0;
            shrink_cnt <= '0;
            hold_cnt   <= '0;
            dead_q     <= 1'b0;
        end else begin
            dead_q <= (state_d == ST_CRASH);
            case (state_q)
                ST_INIT: begin
                    init_addr  <= (init_addr == LAST_ADDR) ? '0 : init_addr + 1'b1;
                    head       <= '0;
                    width      <= W_INIT;
                    xpos       <= CENTER_X;
                    shrink_cnt <= '0;
                    hold_cnt   <= '0;
                end
                ST_IDLE: begin
                    if (bus.start)
                        score_q <= '0;
                end
                ST_RUN: begin
                    hold_cnt <= '0;
                    if (bus.tick) begin
                        lfsr       <= lfsr_next;
                        head       <= head_next;
                        width      <= width_next;
                        xpos       <= xpos_next;
                        shrink_cnt <= shrink_hit ? '0 : shrink_cnt + 1'b1;
                        if (score_q != 16'hFFFF)
                            score_q <= score_q + 1'b1;
                    end
                end
                ST_CRASH: begin
                    if (bus.tick)
                        hold_cnt <= hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pixel path: one registered stage from hCount/vCount to rgb
    logic          pix_on, pix_car, pix_road;
    logic [AW-1:0] pix_row, pix_addr;
    logic [2:0]    pix_h;
    logic [11:0]   pix_rgb;

    always_comb begin
        pix_on   = bus.bright && (bus.vCount >= V_FIRST) && ({1'b0, bus.vCount} < V_END) &&
                   (state_q != ST_INIT);
        pix_row  = AW'(bus.vCount - V_FIRST);
        pix_addr = wrap_add(head, pix_row);
        pix_car  = (bus.vCount >= CAR_V_LO) && (bus.vCount <= CAR_V_HI) &&
                   ({1'b0, bus.hCount} + HALF >= {1'b0, xpos}) &&
                   ({1'b0, bus.hCount} <= {1'b0, xpos} + HALF);
        pix_road = (bus.hCount >= left_mem[pix_addr]) && (bus.hCount <= right_mem[pix_addr]);
        pix_h    = bus.hCount[3:1] ^ pix_addr[2:0];
        pix_rgb  = 12'h000;
        if (pix_on) begin
            if (pix_car)
                pix_rgb = 12'hF00;
            else if (pix_road)
                pix_rgb = (pix_h < 3'd2) ? 12'h666 : (pix_h < 3'd4) ? 12'h999 : 12'h444;
            else
                pix_rgb = (pix_h < 3'd2) ? 12'h050 : (pix_h < 3'd4) ? 12'h0F0 : 12'h0A0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rgb_q <= 12'h000;
        else
            rgb_q <= pix_rgb;
    end

    assign bus.rgb       = rgb_q;
    assign bus.dead_flag = dead_q;
    assign bus.state     = state_q;
    assign bus.score     = score_q;
endmodule

// File: tb/tb_road_track_engine.sv
// tb/tb_road_track_engine.sv - random and directed checks against a screen-ordered road model
module tb_road_track_engine;
    localparam int ROWS     = 480;
    localparam int X_MIN    = 144;
    localparam int X_MAX    = 783;
    localparam int V_START  = 35;
    localparam int CENTER   = 464;
    localparam int CAR_ROW  = 340;
    localparam int CAR_HALF = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    road_track_engine_if bm ();
    road_track_engine_if bw ();
    road_track_engine_if bs ();
    road_track_engine_if bf ();

    road_track_engine dut (.clk(clk), .rst(rst), .bus(bm));
    road_track_engine #(.ROAD_W_INIT(600), .ROAD_W_MIN(600)) dut_w (.clk(clk), .rst(rst), .bus(bw));
    road_track_engine #(.SHRINK_PERIOD(4)) dut_s (.clk(clk), .rst(rst), .bus(bs));
    road_track_engine #(.SHRINK_PERIOD(4), .ROAD_W_MIN(90)) dut_f (.clk(clk), .rst(rst), .bus(bf));

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: road kept in screen order, rows[0] is the top visible line
    int        m_state, m_init, m_head, m_x, m_w, m_shr, m_score, m_hold;
    bit [15:0] m_lfsr;
    int        m_rl [ROWS];
    int        m_rr [ROWS];

    task automatic model_init();
        m_head = 0; m_x = CENTER; m_w = 100; m_shr = 0; m_init = 0;
        for (int i = 0; i < ROWS; i++) begin
            m_rl[i] = CENTER - 50;
            m_rr[i] = CENTER + 50;
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lfsr = 16'hACE1; m_score = 0; m_hold = 0;
        model_init();
    endtask

    task automatic model_step(input bit tk, input bit st, input bit lf, input bit rt);
        bit crash;
        int nl;
        case (m_state)
            0: begin
                m_init++;
                if (m_init == ROWS) begin m_state = 1; m_init = 0; end
            end
            1: if (st) begin m_state = 2; m_score = 0; end
            2: begin
                crash = (m_x - CAR_HALF < m_rl[CAR_ROW]) || (m_x + CAR_HALF > m_rr[CAR_ROW]);
                if (tk) begin
                    m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
                    m_shr++;
                    if (m_shr == 256) begin
                        m_shr = 0;
                        m_w = (m_w - 2 > 40) ? m_w - 2 : 40;
                    end
                    nl = m_rl[0] + int'(m_lfsr[7:0]) % 7 - 3;
                    if (nl < X_MIN) nl = X_MIN;
                    if (nl > X_MAX - m_w) nl = X_MAX - m_w;
                    for (int i = ROWS - 1; i > 0; i--) begin
                        m_rl[i] = m_rl[i-1];
                        m_rr[i] = m_rr[i-1];
                    end
                    m_rl[0] = nl;
                    m_rr[0] = nl + m_w;
                    m_head = (m_head + ROWS - 1) % ROWS;
                    if (rt && !lf) m_x = (m_x + 2 > X_MAX - CAR_HALF) ? X_MAX - CAR_HALF : m_x + 2;
                    else if (lf && !rt) m_x = (m_x - 2 < X_MIN + CAR_HALF) ? X_MIN + CAR_HALF : m_x - 2;
                    if (m_score < 65535) m_score++;
                end
                if (crash) begin m_state = 3; m_hold = 0; end
            end
            default: if (tk) begin
                m_hold++;
                if (m_hold == 60) begin m_state = 0; model_init(); end
            end
        endcase
    endtask

    function automatic logic [11:0] exp_rgb(input int hc, input int vc, input bit br);
        int row, addr, h;
        row = vc - V_START;
        if (!br || row < 0 || row >= ROWS || m_state == 0) return 12'h000;
        if (vc >= CAR_ROW + V_START - CAR_HALF && vc <= CAR_ROW + V_START + CAR_HALF &&
            hc >= m_x - CAR_HALF && hc <= m_x + CAR_HALF) return 12'hF00;
        addr = (m_head + row) % ROWS;
        h = ((hc >> 1) & 7) ^ (addr & 7);
        if (hc >= m_rl[row] && hc <= m_rr[row])
            return (h < 2) ? 12'h666 : (h < 4) ? 12'h999 : 12'h444;
        return (h < 2) ? 12'h050 : (h < 4) ? 12'h0F0 : 12'h0A0;
    endfunction

    task automatic cycle();
        logic [11:0] er;
        er = exp_rgb(int'(bm.hCount), int'(bm.vCount), bm.bright);
        model_step(bm.tick, bm.start, bm.left, bm.right);
        @(posedge clk);
        #1;
        check_eq("state", 32'(bm.state), m_state);
        check_eq("dead_flag", 32'(bm.dead_flag), 32'(m_state == 3));
        check_eq("score", 32'(bm.score), m_score);
        check_eq("rgb", 32'(bm.rgb), 32'(er));
        @(negedge clk);
    endtask

    task automatic tick_pulse();
        bm.tick = 1'b1;
        cycle();
        bm.tick = 1'b0;
        cycle();
    endtask

    task automatic aux_drive(input bit tk, input bit st);
        bw.tick = tk; bs.tick = tk; bf.tick = tk;
        bw.start = st; bs.start = st; bf.start = st;
    endtask

    initial begin
        int bad, bad_adj, a, nxt, d;
        bit steer_l, steer_r;

        bm.tick = 0; bm.start = 0; bm.left = 0; bm.right = 0; bm.bright = 0;
        bm.hCount = '0; bm.vCount = '0;
        aux_drive(1'b0, 1'b0);
        bw.left = 0; bw.right = 0; bw.bright = 0; bw.hCount = '0; bw.vCount = '0;
        bs.left = 0; bs.right = 0; bs.bright = 0; bs.hCount = '0; bs.vCount = '0;
        bf.left = 0; bf.right = 0; bf.bright = 0; bf.hCount = '0; bf.vCount = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_state", 32'(bm.state), 0);
        check_eq("rst_rgb", 32'(bm.rgb), 0);
        check_eq("rst_score", 32'(bm.score), 0);
        check_eq("rst_dead", 32'(bm.dead_flag), 0);
        check_eq("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
        @(negedge clk);
        rst = 1'b0;

        repeat (479) cycle();
        check_eq("init_480", 32'(bm.state), 0);
        cycle();
        check_eq("idle_481", 32'(bm.state), 1);
        bad = 0;
        for (int i = 0; i < ROWS; i++)
            if (dut.left_mem[i] != 10'd414 || dut.right_mem[i] != 10'd514) bad++;
        check_eq("init_rows", bad, 0);
        check_eq("init_xpos", 32'(dut.xpos), 464);

        bm.bright = 1; bm.hCount = 10'd464; bm.vCount = 10'd375;
        cycle();
        check_eq("pix_car", 32'(bm.rgb), 32'hF00);
        bm.bright = 0;
        cycle();
        check_eq("pix_dark", 32'(bm.rgb), 0);
        bm.bright = 1; bm.hCount = 10'd414; bm.vCount = 10'd100;
        cycle();
        check_eq("pix_road", 32'(bm.rgb), 32'h444);

        aux_drive(1'b0, 1'b1);
        cycle();
        aux_drive(1'b0, 1'b0);
        for (int t = 1; t <= 2000; t++) begin
            aux_drive(1'b1, 1'b0);
            cycle();
            aux_drive(1'b0, 1'b0);
            cycle();
            if (t == 40) begin
                check_eq("shrink_w80", 32'(dut_s.right_mem[dut_s.head] - dut_s.left_mem[dut_s.head]), 80);
                check_eq("shrink_floor90", 32'(dut_f.right_mem[dut_f.head] - dut_f.left_mem[dut_f.head]), 90);
            end
        end
        check_eq("wide_state", 32'(bw.state), 2);
        check_eq("wide_score", 32'(bw.score), 2000);
        check_eq("wide_head", 32'(dut_w.head), 400);
        bad = 0; bad_adj = 0;
        for (int r = 0; r < ROWS; r++) begin
            a = (int'(dut_w.head) + r) % ROWS;
            if (int'(dut_w.left_mem[a]) < X_MIN || int'(dut_w.right_mem[a]) > X_MAX) bad++;
            if (r < ROWS - 1) begin
                nxt = (a + 1) % ROWS;
                d = int'(dut_w.left_mem[a]) - int'(dut_w.left_mem[nxt]);
                if (d > 3 || d < -3) bad_adj++;
            end
        end
        check_eq("wide_bounds", bad, 0);
        check_eq("wide_curve", bad_adj, 0);

        bm.start = 1;
        cycle();
        bm.start = 0; bm.right = 1;
        for (int t = 1; t <= 22; t++) tick_pulse();
        check_eq("no_crash_t22", 32'(bm.state), 2);
        tick_pulse();
        check_eq("crash_dead", 32'(bm.dead_flag), 1);
        check_eq("crash_state", 32'(bm.state), 3);
        check_eq("crash_score", 32'(bm.score), 23);
        for (int t = 1; t <= 59; t++) tick_pulse();
        check_eq("hold_59", 32'(bm.state), 3);
        tick_pulse();
        check_eq("reinit_60", 32'(bm.state), 0);
        bm.right = 0;
        repeat (479) cycle();
        check_eq("reidle", 32'(bm.state), 1);

        bm.start = 1;
        cycle();
        bm.start = 0; bm.left = 1; bm.right = 1;
        for (int t = 1; t <= 100; t++) tick_pulse();
        check_eq("both_score", 32'(bm.score), 100);
        check_eq("both_state", 32'(bm.state), 2);
        check_eq("both_xpos", 32'(dut.xpos), 464);

        #2 rst = 1'b1;
        #1;
        check_eq("midrst_state", 32'(bm.state), 0);
        check_eq("midrst_dead", 32'(bm.dead_flag), 0);
        check_eq("midrst_rgb", 32'(bm.rgb), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_lfsr", 32'(dut.lfsr), 32'hACE1);
        check_eq("midrst_score", 32'(bm.score), 0);
        bm.left = 0; bm.right = 0;

        steer_l = 0; steer_r = 0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                steer_l = 1'($urandom_range(0, 1));
                steer_r = 1'($urandom_range(0, 1));
            end
            bm.left   = steer_l;
            bm.right  = steer_r;
            bm.tick   = ($urandom_range(0, 2) == 0);
            bm.start  = ($urandom_range(0, 15) == 0);
            bm.bright = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0)
                bm.hCount = 10'($urandom_range(100, 820));
            else
                bm.hCount = 10'(m_x - 60 + int'($urandom_range(0, 120)));
            bm.vCount = 10'($urandom_range(20, 530));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
